int_source: RTL

INT_SOURCE -- requirements
Module: int_source

---
 rtl/int_source.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/int_source.sv
// Edge-triggered interrupt source: latches rising edges on peripheral event
// lines into a W1C pending register and drives a level interrupt with a gap.
module int_source #(
  parameter int NSRC = 8,
  parameter int GAP  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NSRC-1:0] ev_i,
  input  logic [1:0]      addr_i,
  input  logic [7:0]      wdata_i,
  input  logic            we_i,
  output logic [7:0]      rdata_o,
  output logic            int_o
);

  localparam int CW = $clog2(GAP) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  logic [NSRC-1:0] ev_q;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] pend_d;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] mask_d;
  logic [NSRC-1:0] edge_s;
  logic [NSRC-1:0] clr_s;
  logic [NSRC-1:0] act_s;
  logic [NSRC-1:0] act_d_s;
  logic            any_s;
  logic            any_d_s;
  logic            ack_s;
  logic            wr_pend_s;
  logic            wr_mask_s;
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            int_q;

  function automatic logic [2:0] lowest_idx(input logic [NSRC-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Edge detect, W1C pending update (set wins over clear), mask load, and the
  // acknowledge condition that forces a fresh interrupt edge.
  always_comb begin
    wr_pend_s = we_i && (addr_i == 2'd0);
    wr_mask_s = we_i && (addr_i == 2'd1);
    edge_s    = ev_i & ~ev_q;
    if (wr_pend_s) begin
      clr_s = wdata_i[NSRC-1:0];
    end else begin
      clr_s = '0;
    end
    pend_d = (pend_q & ~clr_s) | edge_s;
    if (wr_mask_s) begin
      mask_d = wdata_i[NSRC-1:0];
    end else begin
      mask_d = mask_q;
    end
    act_s   = pend_q & mask_q;
    any_s   = |act_s;
    act_d_s = pend_d & mask_d;
    any_d_s = |act_d_s;
    ack_s   = |(clr_s & act_s);
  end

  // Register read mux.
  always_comb begin
    case (addr_i)
      2'd0:    rdata_o = 8'(pend_q);
      2'd1:    rdata_o = 8'(mask_q);
      2'd2:    rdata_o = {any_s, 4'b0000, lowest_idx(act_s)};
      default: rdata_o = 8'h00;
    endcase
  end

  // Event history, pending and mask registers.
  always_ff @(posedge clk_i) begin
    ev_q <= ev_i;
    if (rst_i) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // Interrupt FSM; a cause being cleared in the same cycle does not raise int.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      int_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_s && any_d_s) begin
            state_q <= S_ASSERT;
            int_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            int_q   <= 1'b0;
          end
        end
        S_ASSERT: begin
          if (!any_d_s || ack_s) begin
            state_q <= S_GAP;
            cnt_q   <= CW'(GAP - 1);
            int_q   <= 1'b0;
          end else begin
            state_q <= S_ASSERT;
            int_q   <= 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            if (any_s && any_d_s) begin
              state_q <= S_ASSERT;
              int_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              int_q   <= 1'b0;
            end
          end else begin
            cnt_q   <= cnt_q - CW'(1);
            int_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          int_q   <= 1'b0;
        end
      endcase
    end
  end

  assign int_o = int_q;

endmodule
